// File: rtl/elevator_scheduler.sv
// SCAN-style elevator car scheduler: latches floor calls, runs car motion and
// door dwell from a shared down-counter, and presents the next stop one-hot.
module elevator_scheduler #(
  parameter int NUM_FLOORS    = 8,
  parameter int TRAVEL_CYCLES = 50000000,
  parameter int DOOR_CYCLES   = 100000000,
  parameter int FLOOR_W       = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic                  door_hold,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic [NUM_FLOORS-1:0] destination,
  output logic [1:0]            sim_state,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  arrive
);

  localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TIMER_W = $clog2(MAX_CYC + 1);
  localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_UP   = 2'b01,
    S_DOWN = 2'b10,
    S_DOOR = 2'b11
  } state_t;

  state_t                  state_q, state_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic                    dir_up_q, dir_up_d;
  logic                    arrive_q, arrive_d;

  logic                    above, below;
  logic [NUM_FLOORS-1:0]   cur_onehot, up_sel, dn_sel;
  logic [FLOOR_W-1:0]      step_floor;
  logic [NUM_FLOORS-1:0]   step_onehot;
  logic                    here_call;

  // Request summary relative to the car, plus nearest stop on each side.
  always_comb begin
    above  = 1'b0;
    below  = 1'b0;
    up_sel = '0;
    dn_sel = '0;
    cur_onehot = '0;
    cur_onehot[floor_q] = 1'b1;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending_q[i] && (i > int'(floor_q))) begin
        above  = 1'b1;
        up_sel = '0;
        up_sel[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_q[i] && (i < int'(floor_q))) begin
        below  = 1'b1;
        dn_sel = '0;
        dn_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    destination = cur_onehot;
    if (state_q == S_UP && above) begin
      destination = up_sel;
    end else if (state_q == S_DOWN && below) begin
      destination = dn_sel;
    end
  end

  // Floor the car reaches when the travel timer expires; clamped at the shaft ends.
  always_comb begin
    step_floor = floor_q;
    if (state_q == S_UP && floor_q != TOP_FLOOR) begin
      step_floor = floor_q + FLOOR_W'(1);
    end else if (state_q == S_DOWN && floor_q != '0) begin
      step_floor = floor_q - FLOOR_W'(1);
    end
    step_onehot = '0;
    step_onehot[step_floor] = 1'b1;
  end

  assign here_call = call_req[floor_q];

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    pending_d = pending_q | call_req;
    timer_d   = timer_q;
    dir_up_d  = dir_up_q;
    arrive_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        pending_d = pending_q | (call_req & ~cur_onehot);
        if (here_call) begin
          state_d  = S_DOOR;
          timer_d  = DOOR_LOAD;
          arrive_d = 1'b1;
        end else if (above && (dir_up_q || !below)) begin
          state_d  = S_UP;
          dir_up_d = 1'b1;
          timer_d  = TRAVEL_LOAD;
        end else if (below) begin
          state_d  = S_DOWN;
          dir_up_d = 1'b0;
          timer_d  = TRAVEL_LOAD;
        end
      end

      S_UP, S_DOWN: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TIMER_W'(1);
        end else begin
          floor_d = step_floor;
          // A call for the arrival floor in the arrival cycle is absorbed by this stop.
          if (pending_q[step_floor] || call_req[step_floor]) begin
            pending_d = (pending_q | call_req) & ~step_onehot;
            state_d   = S_DOOR;
            timer_d   = DOOR_LOAD;
            arrive_d  = 1'b1;
          end else begin
            timer_d = TRAVEL_LOAD;
          end
        end
      end

      S_DOOR: begin
        pending_d = pending_q | (call_req & ~cur_onehot);
        if (door_hold || here_call) begin
          timer_d = DOOR_LOAD;
        end else if (timer_q != '0) begin
          timer_d = timer_q - TIMER_W'(1);
        end else if (dir_up_q && above) begin
          state_d = S_UP;
          timer_d = TRAVEL_LOAD;
        end else if (!dir_up_q && below) begin
          state_d = S_DOWN;
          timer_d = TRAVEL_LOAD;
        end else if (below) begin
          state_d  = S_DOWN;
          dir_up_d = 1'b0;
          timer_d  = TRAVEL_LOAD;
        end else if (above) begin
          state_d  = S_UP;
          dir_up_d = 1'b1;
          timer_d  = TRAVEL_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      floor_q   <= '0;
      pending_q <= '0;
      timer_q   <= '0;
      dir_up_q  <= 1'b1;
      arrive_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      dir_up_q  <= dir_up_d;
      arrive_q  <= arrive_d;
    end
  end

  assign current_floor = floor_q;
  assign sim_state     = state_q;
  assign pending       = pending_q;
  assign arrive        = arrive_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler (8 floors, 4-cycle travel, 3-cycle door).
// Each expected stop floor is queued by the stimulus; a monitor pops it on arrive.
module tb_elevator_scheduler;

  localparam int NF = 8;
  localparam int TC = 4;
  localparam int DC = 3;
  localparam int FW = 3;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [NF-1:0] call_req = '0;
  logic          door_hold = 1'b0;
  logic [FW-1:0] current_floor;
  logic [NF-1:0] destination;
  logic [1:0]    sim_state;
  logic [NF-1:0] pending;
  logic          arrive;

  int            n_cmp = 0;
  int            n_fail = 0;
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] mon_f;

  elevator_scheduler #(
    .NUM_FLOORS(NF),
    .TRAVEL_CYCLES(TC),
    .DOOR_CYCLES(DC),
    .FLOOR_W(FW)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .call_req(call_req),
    .door_hold(door_hold),
    .current_floor(current_floor),
    .destination(destination),
    .sim_state(sim_state),
    .pending(pending),
    .arrive(arrive)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic pulse_call(input logic [NF-1:0] v);
    call_req = v;
    @(negedge clk);
    call_req = '0;
  endtask

  task automatic wait_arrive(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!arrive && n < budget);
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sim_state !== s && n < budget);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (nrst && arrive) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL arrive_unexpected: arrive at floor %0d, none queued", current_floor);
      end else begin
        mon_f = exp_q.pop_front();
        check("arrive_floor", 32'(current_floor), 32'(mon_f));
        check("arrive_state", 32'(sim_state), 32'd3);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int held;

    // power-on reset
    repeat (2) @(negedge clk);
    check("rst_state", 32'(sim_state), 32'd0);
    check("rst_floor", 32'(current_floor), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_dest", 32'(destination), 32'h01);
    check("rst_arrive", 32'(arrive), 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    // reset while moving up abandons the trip and the call
    pulse_call(8'h80);
    @(negedge clk);
    check("mid_move_state", 32'(sim_state), 32'd1);
    repeat (5) @(negedge clk);
    check("mid_move_floor", 32'(current_floor), 32'd1);
    #2 nrst = 1'b0;
    #1;
    check("async_rst_state", 32'(sim_state), 32'd0);
    check("async_rst_floor", 32'(current_floor), 32'd0);
    check("async_rst_pending", 32'(pending), 32'd0);
    check("async_rst_dest", 32'(destination), 32'h01);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // single call to floor 3
    exp_q.push_back(3'd3);
    pulse_call(8'h08);
    check("single_pending", 32'(pending), 32'h08);
    check("single_still_idle", 32'(sim_state), 32'd0);
    @(negedge clk);
    check("single_move_up", 32'(sim_state), 32'd1);
    check("single_dest", 32'(destination), 32'h08);
    wait_arrive(100, n);
    check("single_travel_cycles", 32'(n), 32'd12);
    check("single_pending_cleared", 32'(pending), 32'd0);
    wait_state(2'b00, 100, n);
    check("single_door_cycles", 32'(n), 32'd3);
    check("single_idle_floor", 32'(current_floor), 32'd3);
    check("single_idle_dest", 32'(destination), 32'h08);

    // SCAN: at 3 heading up with calls at 1 and 6
    exp_q.push_back(3'd6);
    exp_q.push_back(3'd1);
    pulse_call(8'h42);
    @(negedge clk);
    check("scan_up_state", 32'(sim_state), 32'd1);
    check("scan_up_dest", 32'(destination), 32'h40);
    wait_arrive(100, n);
    check("scan_up_cycles", 32'(n), 32'd12);
    wait_state(2'b10, 100, n);
    check("scan_reverse_cycles", 32'(n), 32'd3);
    check("scan_down_dest", 32'(destination), 32'h02);
    wait_arrive(100, n);
    check("scan_down_cycles", 32'(n), 32'd20);
    wait_state(2'b00, 100, n);
    check("scan_idle_floor", 32'(current_floor), 32'd1);

    // move to floor 2, then same-floor call with a reopen at door timer zero
    exp_q.push_back(3'd2);
    pulse_call(8'h04);
    @(negedge clk);
    check("to2_state", 32'(sim_state), 32'd1);
    wait_arrive(100, n);
    check("to2_cycles", 32'(n), 32'd4);
    wait_state(2'b00, 100, n);
    exp_q.push_back(3'd2);
    pulse_call(8'h04);
    check("same_floor_door", 32'(sim_state), 32'd3);
    check("same_floor_pending", 32'(pending), 32'd0);
    repeat (2) @(negedge clk);
    pulse_call(8'h04);
    check("reopen_still_open", 32'(sim_state), 32'd3);
    wait_state(2'b00, 100, n);
    check("reopen_cycles", 32'(n), 32'd3);

    // door_hold keeps the door open
    exp_q.push_back(3'd2);
    pulse_call(8'h04);
    door_hold = 1'b1;
    held = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sim_state === 2'b11) held++;
    end
    door_hold = 1'b0;
    check("hold_open_cycles", 32'(held), 32'd10);
    wait_state(2'b00, 100, n);
    check("hold_release_cycles", 32'(n), 32'd3);

    // back down to floor 0
    exp_q.push_back(3'd0);
    pulse_call(8'h01);
    @(negedge clk);
    check("to0_state", 32'(sim_state), 32'd2);
    wait_arrive(100, n);
    check("to0_cycles", 32'(n), 32'd8);
    wait_state(2'b00, 100, n);

    // all floors at once: bit 0 opens the door here, then stops 1..7 in order
    exp_q.push_back(3'd0);
    for (int f = 1; f < NF; f++) exp_q.push_back(3'(f));
    pulse_call(8'hFF);
    check("all_pending", 32'(pending), 32'hFE);
    for (int f = 1; f < NF; f++) begin
      wait_arrive(100, n);
      check("all_stop_cycles", 32'(n), 32'd7);
    end
    wait_state(2'b00, 100, n);
    check("all_final_door", 32'(n), 32'd3);
    check("all_final_floor", 32'(current_floor), 32'd7);
    check("all_final_pending", 32'(pending), 32'd0);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
